// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encodings,
// requester count and the transmitter bit-period constant.
package uart_tx_arbiter_pkg;

  localparam int NUM_REQ = 4;

  // Transmitter clocks per bit; the transmitter is a separate block and
  // shares this constant with the arbiter environment.
  localparam int CLK_DIV = 4;

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the UART transmit arbiter.
interface uart_tx_arbiter_if;
  import uart_tx_arbiter_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_we;
  logic                 tx_busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_last, req_data, tx_busy,
    output req_ready, tx_data, tx_we
  );

  // Requesters and transmitter side
  modport master (
    output req_valid, req_last, req_data, tx_busy,
    input  req_ready, tx_data, tx_we
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or after last+1,
// wrapping, with the last grantee itself checked last.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // Scan requesters in rotating priority order
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmit arbiter: grants one of four byte requesters a packet lock,
// feeds its bytes to the transmitter one at a time paced by tx_busy, and
// revokes a lock whose owner goes quiet for LOCK_TIMEOUT cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB       | no owner; pick next requester round-robin
// ISSUE     | owner locked; send its byte once valid and transmitter idle
// WAIT_BUSY | byte written; wait for transmitter to report busy
// WAIT_IDLE | transmitter busy; on idle release lock or issue next byte
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               resetn,
  uart_tx_arbiter_if.slave   bus,
  output logic [1:0]         grant_id,
  output logic               locked,
  output logic [15:0]        bytes_sent
);

  uart_tx_arbiter_pkg::arb_state_t state;

  logic [1:0]         last_grant;
  logic               last_q;
  logic [31:0]        idle_cnt;
  logic               pick_found;
  logic [1:0]         pick_idx;
  logic               cur_valid;
  logic               issue_fire;
  logic [NUM_REQ-1:0] ready_vec;

  uart_rr_pick u_pick (
    .req   (bus.req_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cur_valid  = bus.req_valid[grant_id];
  assign issue_fire = (state == uart_tx_arbiter_pkg::ST_ISSUE) && cur_valid && !bus.tx_busy;

  // Only the owner is offered ready, and only in the cycle its byte goes out
  always_comb begin
    ready_vec = '0;
    if (issue_fire) ready_vec[grant_id] = 1'b1;
  end

  assign bus.req_ready = ready_vec[3:0];
  assign bus.tx_we     = |(bus.req_valid & bus.req_ready);
  assign bus.tx_data   = issue_fire ? bus.req_data[{grant_id, 3'b000} +: 8] : 8'h00;

  // Arbitration FSM, lock/idle tracking and sent-byte counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= uart_tx_arbiter_pkg::ST_ARB;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      locked     <= 1'b0;
      last_q     <= 1'b0;
      idle_cnt   <= '0;
      bytes_sent <= 16'h0000;
    end else begin
      if (bus.tx_we) bytes_sent <= bytes_sent + 16'd1;

      case (state)
        uart_tx_arbiter_pkg::ST_ARB: begin
          if (pick_found) begin
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            locked     <= 1'b1;
            idle_cnt   <= '0;
            state      <= uart_tx_arbiter_pkg::ST_ISSUE;
          end
        end

        uart_tx_arbiter_pkg::ST_ISSUE: begin
          if (issue_fire) begin
            last_q   <= bus.req_last[grant_id];
            idle_cnt <= '0;
            state    <= uart_tx_arbiter_pkg::ST_WAIT_BUSY;
          end else if (!cur_valid && (LOCK_TIMEOUT != 0)) begin
            // Owner went quiet mid-packet: give the channel back after
            // LOCK_TIMEOUT consecutive idle cycles.
            if (idle_cnt == 32'(LOCK_TIMEOUT - 1)) begin
              locked   <= 1'b0;
              idle_cnt <= '0;
              state    <= uart_tx_arbiter_pkg::ST_ARB;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end
        end

        uart_tx_arbiter_pkg::ST_WAIT_BUSY: begin
          if (bus.tx_busy) state <= uart_tx_arbiter_pkg::ST_WAIT_IDLE;
        end

        uart_tx_arbiter_pkg::ST_WAIT_IDLE: begin
          if (!bus.tx_busy) begin
            if (last_q) begin
              locked <= 1'b0;
              state  <= uart_tx_arbiter_pkg::ST_ARB;
            end else begin
              state  <= uart_tx_arbiter_pkg::ST_ISSUE;
            end
          end
        end

        default: state <= uart_tx_arbiter_pkg::ST_ARB;
      endcase
    end
  end

endmodule
